// File: rtl/floo_pkg.sv
// Shared types for the reduction fold stage: flit layout, reduction opcodes and fold-state encoding.
package floo_pkg;

    localparam int unsigned RedDataWidth = 64;
    localparam int unsigned HdrWidth     = 16;

    typedef logic [HdrWidth-1:0] hdr_t;

    typedef struct packed {
        hdr_t                    hdr;
        logic [RedDataWidth-1:0] payload;
    } flit_t;

    typedef enum logic [2:0] {
        Add, And, Or, Xor, UMax, UMin, SMax, SMin
    } red_op_e;

    typedef enum logic [1:0] {
        Idle, Fold, Out
    } fold_state_e;

endpackage

// File: rtl/floo_reduction_alu.sv
// Combinational two-operand reduction operator.
// FLOO_REDUCTION_SIGNED_EN enables true two's-complement SMax/SMin; otherwise they fall back to UMax/UMin.
module floo_reduction_alu
    import floo_pkg::*;
#(
    parameter int unsigned DataWidth = RedDataWidth
) (
    input  red_op_e              op_i,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic [DataWidth-1:0] result_o
);

    always_comb begin
        result_o = a_i;
        case (op_i)
            Add:  result_o = a_i + b_i;
            And:  result_o = a_i & b_i;
            Or:   result_o = a_i | b_i;
            Xor:  result_o = a_i ^ b_i;
            UMax: result_o = (a_i > b_i) ? a_i : b_i;
            UMin: result_o = (a_i < b_i) ? a_i : b_i;
`ifdef FLOO_REDUCTION_SIGNED_EN
            SMax: result_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
            SMin: result_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
`else
            SMax: result_o = (a_i > b_i) ? a_i : b_i;
            SMin: result_o = (a_i < b_i) ? a_i : b_i;
`endif
            default: result_o = a_i;
        endcase
    end

endmodule

// File: rtl/floo_reduction_fold.sv
// Folds the payloads of all masked input ports into one flit, one operand per cycle, then pops them together.
// Signed SMax/SMin are available when FLOO_REDUCTION_SIGNED_EN is defined.
module floo_reduction_fold
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes = 5,
    parameter int unsigned DataWidth = RedDataWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  flit_t [NumRoutes-1:0]         flit_i,
    input  logic                          sync_valid_i,
    input  logic [NumRoutes-1:0]          in_mask_i,
    input  red_op_e                       op_i,
    output logic [NumRoutes-1:0]          ready_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output flit_t                         flit_o
);

    localparam int unsigned IdxW = (NumRoutes > 1) ? $clog2(NumRoutes) : 1;
    typedef logic [IdxW-1:0] idx_t;

    function automatic idx_t lowestSetIdx(input logic [NumRoutes-1:0] m);
        idx_t idx;
        idx = '0;
        for (int i = int'(NumRoutes) - 1; i >= 0; i--) begin
            if (m[i]) idx = idx_t'(i);
        end
        return idx;
    endfunction

    fold_state_e          state_q, state_d;
    logic [NumRoutes-1:0] mask_q, mask_d;
    logic [NumRoutes-1:0] popMask_q, popMask_d;
    red_op_e              op_q, op_d;
    hdr_t                 head_q, head_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic                 first_q, first_d;

    idx_t                 foldIdx;
    logic [DataWidth-1:0] operand;
    logic [DataWidth-1:0] aluResult;

    assign foldIdx = lowestSetIdx(mask_q);
    assign operand = flit_i[foldIdx].payload;

    floo_reduction_alu #(
        .DataWidth (DataWidth)
    ) i_alu (
        .op_i     (op_q),
        .a_i      (acc_q),
        .b_i      (operand),
        .result_o (aluResult)
    );

    // mask_q tracks operands still to fold; popMask_q keeps the original set for the single pop strobe.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        popMask_d = popMask_q;
        op_d      = op_q;
        head_d    = head_q;
        acc_d     = acc_q;
        first_d   = first_q;
        ready_o   = '0;
        valid_o   = 1'b0;
        flit_o    = '0;
        case (state_q)
            Idle: begin
                if (sync_valid_i && (|in_mask_i)) begin
                    mask_d    = in_mask_i;
                    popMask_d = in_mask_i;
                    op_d      = op_i;
                    head_d    = flit_i[lowestSetIdx(in_mask_i)].hdr;
                    first_d   = 1'b1;
                    state_d   = Fold;
                end
            end
            Fold: begin
                acc_d   = first_q ? operand : aluResult;
                first_d = 1'b0;
                mask_d  = mask_q & ~(NumRoutes'(1) << foldIdx);
                if (mask_d == '0) begin
                    ready_o = popMask_q;
                    state_d = Out;
                end
            end
            Out: begin
                valid_o        = 1'b1;
                flit_o.hdr     = head_q;
                flit_o.payload = acc_q;
                if (ready_i) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            mask_q    <= '0;
            popMask_q <= '0;
            op_q      <= Add;
            head_q    <= '0;
            acc_q     <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            popMask_q <= popMask_d;
            op_q      <= op_d;
            head_q    <= head_d;
            acc_q     <= acc_d;
            first_q   <= first_d;
        end
    end

endmodule

// File: tb/tb_floo_reduction_fold.sv
// Directed plus randomized bench for floo_reduction_fold against an in-order fold reference model.
module tb_floo_reduction_fold;
    import floo_pkg::*;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    flit_t [4:0]       flitI;
    logic              syncValid = 1'b0;
    logic [4:0]        inMask = '0;
    red_op_e           opI = Add;
    logic [4:0]        readyO;
    logic              validO;
    logic              readyI = 1'b1;
    flit_t             flitO;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] payArr [5];
    hdr_t        hdrArr [5];
    logic [63:0] nextPay [5];
    hdr_t        nextHdr [5];
    red_op_e     nextOp;
    logic [4:0]  nextMask;
    flit_t       lastFlit;

    floo_reduction_fold #(
        .NumRoutes (5),
        .DataWidth (64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .flit_i       (flitI),
        .sync_valid_i (syncValid),
        .in_mask_i    (inMask),
        .op_i         (opI),
        .ready_o      (readyO),
        .valid_o      (validO),
        .ready_i      (readyI),
        .flit_o       (flitO)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] refOp(input red_op_e op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            Add:  return a + b;
            And:  return a & b;
            Or:   return a | b;
            Xor:  return a ^ b;
            UMax: return (a >= b) ? a : b;
            UMin: return (a <= b) ? a : b;
`ifdef FLOO_REDUCTION_SIGNED_EN
            SMax: return ($signed(a) >= $signed(b)) ? a : b;
            SMin: return ($signed(a) <= $signed(b)) ? a : b;
`else
            SMax: return (a >= b) ? a : b;
            SMin: return (a <= b) ? a : b;
`endif
            default: return a;
        endcase
    endfunction

    // Participants are folded in ascending port order; header comes from the lowest participant.
    function automatic flit_t refFlit(input red_op_e op, input logic [4:0] mask);
        flit_t r;
        bit    first;
        r = '0;
        first = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (mask[i]) begin
                if (first) begin
                    r.payload = payArr[i];
                    r.hdr     = hdrArr[i];
                    first     = 1'b0;
                end else begin
                    r.payload = refOp(op, r.payload, payArr[i]);
                end
            end
        end
        return r;
    endfunction

    task automatic driveFlits();
        for (int i = 0; i < 5; i++) begin
            flitI[i].hdr     = hdrArr[i];
            flitI[i].payload = payArr[i];
        end
    endtask

    task automatic randomFlits();
        for (int i = 0; i < 5; i++) begin
            payArr[i] = {$urandom, $urandom};
            hdrArr[i] = hdr_t'($urandom);
        end
    endtask

    task automatic applyStimulus(input red_op_e op, input logic [4:0] mask);
        driveFlits();
        opI       = op;
        inMask    = mask;
        syncValid = 1'b1;
    endtask

    // Called at a negedge where the accept is being presented; follows the fold through the handshake.
    task automatic checkOutput(input red_op_e op, input logic [4:0] mask, input string tag,
                               input int bpCycles, input bit preloadNext);
        flit_t      exp;
        int         n, pulses, pulseAt, cnt;
        logic [4:0] pulseVal;
        exp      = refFlit(op, mask);
        cnt      = $countones(mask);
        n        = 0;
        pulses   = 0;
        pulseAt  = -1;
        pulseVal = '0;
        readyI   = (bpCycles == 0);
        while (!validO && n < 40) begin
            @(negedge clk);
            n++;
            syncValid = 1'b0;
            if (readyO != '0) begin
                pulses++;
                pulseAt  = n;
                pulseVal = readyO;
            end
        end
        lastFlit = flitO;
        compared++;
        assert (n === cnt + 1) else begin
            mismatched++;
            $error("[TB] FAIL %s latency: observed %0d expected %0d", tag, n, cnt + 1);
        end
        compared++;
        assert (pulses === 1 && pulseAt === cnt && pulseVal === mask) else begin
            mismatched++;
            $error("[TB] FAIL %s pop: observed pulses=%0d at=%0d val=%b expected 1 at %0d val=%b",
                   tag, pulses, pulseAt, pulseVal, cnt, mask);
        end
        compared++;
        assert (flitO === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s flit: observed hdr=%h pay=%h expected hdr=%h pay=%h",
                   tag, flitO.hdr, flitO.payload, exp.hdr, exp.payload);
        end
        for (int k = 0; k < bpCycles; k++) begin
            if (k == 0 && preloadNext) begin
                for (int i = 0; i < 5; i++) begin
                    payArr[i] = nextPay[i];
                    hdrArr[i] = nextHdr[i];
                end
                applyStimulus(nextOp, nextMask);
            end
            @(negedge clk);
            compared++;
            assert (validO === 1'b1 && flitO === exp && readyO === 5'b0) else begin
                mismatched++;
                $error("[TB] FAIL %s hold%0d: observed v=%b pay=%h rdy=%b expected v=1 pay=%h rdy=0",
                       tag, k, validO, flitO.payload, readyO, exp.payload);
            end
        end
        readyI = 1'b1;
        @(negedge clk);
        compared++;
        assert (validO === 1'b0 && readyO === 5'b0) else begin
            mismatched++;
            $error("[TB] FAIL %s handshake: observed v=%b rdy=%b expected v=0 rdy=0", tag, validO, readyO);
        end
    endtask

    initial begin
        flitI = '0;
        for (int i = 0; i < 5; i++) begin
            payArr[i] = '0;
            hdrArr[i] = '0;
        end
        repeat (3) @(negedge clk);
        compared++;
        assert (validO === 1'b0 && readyO === 5'b0 && flitO === '0) else begin
            mismatched++;
            $error("[TB] FAIL reset: observed v=%b rdy=%b flit=%h expected all zero", validO, readyO, flitO);
        end
        rstN = 1'b1;
        @(negedge clk);

        // Zero mask with valid must be ignored.
        applyStimulus(Add, 5'b00000);
        repeat (3) @(negedge clk);
        compared++;
        assert (validO === 1'b0 && readyO === 5'b0) else begin
            mismatched++;
            $error("[TB] FAIL zeromask: observed v=%b rdy=%b expected v=0 rdy=0", validO, readyO);
        end
        syncValid = 1'b0;
        @(negedge clk);

        randomFlits();
        payArr[1] = 64'd3; payArr[2] = 64'd7; payArr[4] = 64'd9; hdrArr[1] = 16'h1111;
        applyStimulus(Add, 5'b10110);
        checkOutput(Add, 5'b10110, "add3", 0, 1'b0);
        compared++;
        assert (lastFlit.payload === 64'd19 && lastFlit.hdr === 16'h1111) else begin
            mismatched++;
            $error("[TB] FAIL add3const: observed pay=%0d hdr=%h expected pay=19 hdr=1111",
                   lastFlit.payload, lastFlit.hdr);
        end

        randomFlits();
        payArr[0] = 64'hFFFF_FFFF_FFFF_FFFF; payArr[3] = 64'd2;
        applyStimulus(Add, 5'b01001);
        checkOutput(Add, 5'b01001, "addwrap", 0, 1'b0);
        compared++;
        assert (lastFlit.payload === 64'd1) else begin
            mismatched++;
            $error("[TB] FAIL addwrapconst: observed %h expected 1", lastFlit.payload);
        end

        randomFlits();
        payArr[0] = 64'hAB;
        applyStimulus(UMin, 5'b00001);
        checkOutput(UMin, 5'b00001, "pass", 0, 1'b0);
        compared++;
        assert (lastFlit.payload === 64'hAB) else begin
            mismatched++;
            $error("[TB] FAIL passconst: observed %h expected ab", lastFlit.payload);
        end

        // Backpressure for 5 Out cycles with the next fold already offered; it starts right after the handshake.
        randomFlits();
        for (int i = 0; i < 5; i++) begin
            nextPay[i] = {$urandom, $urandom};
            nextHdr[i] = hdr_t'($urandom);
        end
        nextOp   = Xor;
        nextMask = 5'b01100;
        applyStimulus(Or, 5'b11001);
        checkOutput(Or, 5'b11001, "bp", 5, 1'b1);
        checkOutput(Xor, 5'b01100, "afterbp", 0, 1'b0);

        randomFlits();
        payArr[1] = 64'hFFFF_FFFF_FFFF_FFFF; payArr[2] = 64'd1;
        applyStimulus(SMax, 5'b00110);
        checkOutput(SMax, 5'b00110, "smax", 0, 1'b0);
        compared++;
`ifdef FLOO_REDUCTION_SIGNED_EN
        assert (lastFlit.payload === 64'd1) else begin
            mismatched++;
            $error("[TB] FAIL smaxconst: observed %h expected 1", lastFlit.payload);
        end
`else
        assert (lastFlit.payload === 64'hFFFF_FFFF_FFFF_FFFF) else begin
            mismatched++;
            $error("[TB] FAIL smaxconst: observed %h expected ffffffffffffffff", lastFlit.payload);
        end
`endif

        // Reset asserted during the second Fold cycle of a 3-input fold.
        randomFlits();
        applyStimulus(Add, 5'b00111);
        @(negedge clk);
        syncValid = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        compared++;
        assert (validO === 1'b0 && readyO === 5'b0 && flitO === '0) else begin
            mismatched++;
            $error("[TB] FAIL midreset: observed v=%b rdy=%b flit=%h expected all zero", validO, readyO, flitO);
        end
        @(negedge clk);
        compared++;
        assert (validO === 1'b0 && readyO === 5'b0) else begin
            mismatched++;
            $error("[TB] FAIL inreset: observed v=%b rdy=%b expected v=0 rdy=0", validO, readyO);
        end
        rstN = 1'b1;
        @(negedge clk);
        randomFlits();
        applyStimulus(UMax, 5'b10101);
        checkOutput(UMax, 5'b10101, "postreset", 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            red_op_e    op;
            logic [4:0] m;
            op = red_op_e'($urandom_range(0, 7));
            m  = 5'($urandom_range(1, 31));
            randomFlits();
            if (t % 4 == 0) payArr[$urandom_range(0, 4)] = 64'hFFFF_FFFF_FFFF_FFFF;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(op, m);
            checkOutput(op, m, "rand", int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
